// File: rtl/buffer_write_packer.sv
// buffer_write_packer: packs a valid/ready byte stream into 16-bit words for
// the memory_buffer. It issues one write strobe per word and tracks free
// buffer slots with a credit counter, because the buffer has no full flag.
module buffer_write_packer #(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              rd_ack,
  output logic              w,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  credits,
  output logic              overflow_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BYTE_W-1:0]   r_low;
  logic [DATA_W-1:0]   r_data;
  logic                r_w;
  logic [CNT_W-1:0]    r_credits;
  logic                r_ovf;

  logic                w_ready;
  logic                w_xfer;
  logic                w_load_low;
  logic [DATA_W-1:0]   w_word;
  logic                w_emit;

  // Ready depends only on state and credits; a word is started only with a
  // credit in hand, so the high byte never needs to wait.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = (r_credits != {CNT_W{1'b0}});
      S_HIGH:  w_ready = 1'b1;
      S_EMIT:  w_ready = 1'b0;
      default: w_ready = 1'b0;
    endcase
  end

  assign in_ready = w_ready & ~rst;
  assign w_xfer   = in_valid & in_ready;
  assign w_emit   = (r_state == S_EMIT);

  // Next-state and word assembly; a last byte in IDLE is flushed as a
  // zero-extended half word.
  always_comb begin
    w_state_nxt = r_state;
    w_load_low  = 1'b0;
    w_word      = r_data;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (in_last) begin
            w_word      = {{BYTE_W{1'b0}}, in_byte};
            w_state_nxt = S_EMIT;
          end else begin
            w_load_low  = 1'b1;
            w_state_nxt = S_HIGH;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HIGH: begin
        if (w_xfer) begin
          w_word      = {in_byte, r_low};
          w_state_nxt = S_EMIT;
        end else begin
          w_state_nxt = S_HIGH;
        end
      end
      S_EMIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, held low byte, registered word and write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_low   <= {BYTE_W{1'b0}};
      r_data  <= {DATA_W{1'b0}};
      r_w     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_low) begin
        r_low <= in_byte;
      end
      if (w_state_nxt == S_EMIT) begin
        r_data <= w_word;
      end
      r_w <= (w_state_nxt == S_EMIT);
    end
  end

  // Credit counter: a write consumes one, a read acknowledge returns one;
  // a return while already full saturates and raises the sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= DEPTH_C;
      r_ovf     <= 1'b0;
    end else begin
      if (w_emit && !rd_ack) begin
        r_credits <= r_credits - ONE_C;
      end else if (!w_emit && rd_ack) begin
        if (r_credits == DEPTH_C) begin
          r_ovf <= 1'b1;
        end else begin
          r_credits <= r_credits + ONE_C;
        end
      end
    end
  end

  assign w            = r_w;
  assign data_out     = r_data;
  assign credits      = r_credits;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_buffer_write_packer.sv
// Self-checking bench for buffer_write_packer: a transaction-level reference
// model checked every cycle, plus directed literal expectations.
module tb_buffer_write_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_ready;
  logic        rd_ack;
  logic        w;
  logic [15:0] data_out;
  logic [3:0]  credits;
  logic        overflow_err;

  int vectors;
  int miscompares;
  bit chk_en;

  buffer_write_packer #(
    .DATA_W(16), .BYTE_W(8), .DEPTH(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
    .in_last(in_last), .in_ready(in_ready), .rd_ack(rd_ack), .w(w),
    .data_out(data_out), .credits(credits), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bytes collected into a pending list, a word is emitted
  // the cycle after it completes, credits are plain integer arithmetic.
  byte unsigned m_pend[$];
  bit           m_emit;
  int           m_word;
  int           m_cred;
  bit           m_err;

  function automatic bit m_ready();
    if (rst || m_emit) return 1'b0;
    if (m_pend.size() != 0) return 1'b1;
    return (m_cred > 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend.delete();
      m_emit = 1'b0;
      m_word = 0;
      m_cred = 8;
      m_err  = 1'b0;
    end else begin
      bit xfer;
      bit was_emit;
      xfer     = in_valid && m_ready();
      was_emit = m_emit;
      if (was_emit && !rd_ack) m_cred = m_cred - 1;
      else if (!was_emit && rd_ack) begin
        if (m_cred == 8) m_err = 1'b1;
        else m_cred = m_cred + 1;
      end
      m_emit = 1'b0;
      if (xfer) begin
        m_pend.push_back(in_byte);
        if (m_pend.size() == 2 || in_last) begin
          if (m_pend.size() == 2) m_word = int'(m_pend[1]) * 256 + int'(m_pend[0]);
          else m_word = int'(m_pend[0]);
          m_pend.delete();
          m_emit = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cyc_w",        int'(w),            int'(m_emit));
      check("cyc_data_out", int'(data_out),     m_word);
      check("cyc_credits",  int'(credits),      m_cred);
      check("cyc_in_ready", int'(in_ready),     int'(m_ready()));
      check("cyc_ovf",      int'(overflow_err), int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    rd_ack = 1'b0;
    #1;
    check("rst_w_async", int'(w), 0);
    check("rst_in_ready", int'(in_ready), 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offer one byte until it is accepted; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic last);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
    in_last  = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    chk_en = 1'b0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    in_last = 1'b0;
    rd_ack = 1'b0;
    tick();
    do_reset();
    chk_en = 1'b1;

    // 1. reset state
    tick();
    tick();
    check("t1_credits", int'(credits), 8);
    check("t1_in_ready", int'(in_ready), 1);
    check("t1_w", int'(w), 0);
    check("t1_data_out", int'(data_out), 16'h0000);
    check("t1_ovf", int'(overflow_err), 0);

    // 2. basic pack
    send_byte(8'h05, 1'b0);
    check("t2_no_w_early", int'(w), 0);
    send_byte(8'hC0, 1'b0);
    check("t2_w", int'(w), 1);
    check("t2_data", int'(data_out), 16'hC005);
    check("t2_emit_ready", int'(in_ready), 0);
    tick();
    check("t2_w_single", int'(w), 0);
    check("t2_credits", int'(credits), 7);
    check("t2_data_hold", int'(data_out), 16'hC005);

    // 3. flush on in_last
    send_byte(8'hA5, 1'b1);
    check("t3_w", int'(w), 1);
    check("t3_data", int'(data_out), 16'h00A5);
    tick();
    check("t3_credits", int'(credits), 6);

    // 4. full stall
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'(i + 16), 1'b0);
    check("t4_last_word", int'(data_out), 16'h1F1E);
    tick();
    check("t4_credits0", int'(credits), 0);
    in_valid = 1'b1;
    in_byte = 8'hEE;
    in_last = 1'b1;
    tick();
    tick();
    tick();
    check("t4_stall_ready", int'(in_ready), 0);
    check("t4_stall_w", int'(w), 0);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("t4_credit1", int'(credits), 1);
    check("t4_ready_again", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    check("t4_w17", int'(w), 1);
    check("t4_data17", int'(data_out), 16'h00EE);
    tick();
    check("t4_credits_after", int'(credits), 0);

    // 5a. EMIT coinciding with rd_ack
    do_reset();
    send_byte(8'h01, 1'b1);
    tick();
    check("t5_cred7", int'(credits), 7);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    check("t5_w", int'(w), 1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("t5_cred_same", int'(credits), 7);
    check("t5_ovf_clear", int'(overflow_err), 0);

    // 5b. overflow from reset
    do_reset();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("t5_sat", int'(credits), 8);
    check("t5_ovf", int'(overflow_err), 1);
    send_byte(8'h44, 1'b1);
    tick();
    tick();
    check("t5_ovf_sticky", int'(overflow_err), 1);
    do_reset();
    check("t5_ovf_rst", int'(overflow_err), 0);

    // 6. reset mid-word loses the held byte
    send_byte(8'h11, 1'b0);
    do_reset();
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    check("t6_w", int'(w), 1);
    check("t6_data", int'(data_out), 16'h3322);
    tick();
    check("t6_credits", int'(credits), 7);

    // back-to-back words with reads returning credits
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(8'h60 + 2 * i), 1'b0);
      send_byte(8'(8'h61 + 2 * i), 1'b0);
      rd_ack = (i % 2 == 0);
      tick();
      rd_ack = 1'b0;
    end
    check("tx_credits", int'(credits), 4);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/buffer_write_packer.md
Name: buffer_write_packer

Overview:
- Upstream write-side stage for the 16-bit memory_buffer.
- Accepts an 8-bit byte stream over a valid/ready handshake and packs byte pairs into 16-bit words.
- Presents each word on data_out with a single-cycle w strobe; data_out and w drive the buffer's data_in and w directly.
- The buffer has no full flag, so this block keeps a credit count of free buffer slots. Downstream returns one credit per word read, and the block never writes when credits are zero.

Parameters:
- DATA_W, 16, packed word width; must equal 2*BYTE_W.
- BYTE_W, 8, input byte width.
- DEPTH, 8, buffer capacity in words; this is the initial credit count.
- CNT_W, 4, credit counter width; must hold the value DEPTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  in_byte is valid this cycle
- in_byte  input  BYTE_W  byte from the producer
- in_last  input  1  marks the final byte of a message; a pending half word is flushed
- in_ready  output  1  block accepts in_byte this cycle
- rd_ack  input  1  one-cycle pulse: downstream has read one word, return one credit
- w  output  1  write strobe to memory_buffer, one cycle per word
- data_out  output  DATA_W  packed word to memory_buffer data_in
- credits  output  CNT_W  free buffer slots remaining
- overflow_err  output  1  sticky: credit return was attempted while credits==DEPTH

Behaviour:
Clock and reset:
- One clock, clk, rising edge.
- rst is asynchronous, active-high, and overrides everything.

Reset values:
- State IDLE, w=0, data_out=0, credits=DEPTH, overflow_err=0.
- in_ready=0 while rst=1.
- Reset mid-word discards the held low byte.
- Reset during EMIT cancels the strobe: w drops to 0 immediately, asynchronously.

Handshake:
- A byte transfers on a rising edge where in_valid && in_ready.
- in_byte is ignored when no transfer occurs.

State IDLE (no byte held):
- in_ready = (credits != 0).
- On transfer, in_byte is latched into low[7:0].
- If in_last=0, go to HIGH.
- If in_last=1, the word is {8'h00, byte} and the next state is EMIT.

State HIGH (low byte held):
- in_ready = 1.
- The credit was guaranteed at first-byte acceptance; only an EMIT consumes credits.
- On transfer, the word is {in_byte, low} and the next state is EMIT.
- in_last is irrelevant in this state.

State EMIT (one cycle):
- w=1 and data_out = word.
- in_ready=0.
- Next state is IDLE unconditionally.

Output timing:
- data_out is registered and updates on the edge that enters EMIT.
- data_out holds its value after EMIT until the next EMIT.
- w is registered and high for exactly the one EMIT cycle.
- Latency is one cycle: w is high in the cycle after the completing byte transfers.
- Peak throughput is one word per 3 cycles.

Credits, updated on each edge:
- EMIT alone: credits-1.
- rd_ack alone: credits+1.
- EMIT and rd_ack in the same cycle: credits unchanged.

Credit boundary conditions:
- rd_ack while credits==DEPTH with no EMIT that cycle: credits unchanged (saturate) and overflow_err set to 1.
- overflow_err is cleared only by rst.
- With credits==0 in IDLE: in_ready=0 and the byte stalls. Acceptance resumes in the cycle after an rd_ack edge.

Test Plan:
1. Credit reset: assert rst, release it, hold in_valid=0 for 2 cycles. Expect credits=8, in_ready=1, w=0, data_out=0, overflow_err=0.
2. Basic pack: send bytes 8'h05, then 8'hC0, with in_last=0. Expect w=1 for exactly one cycle, the cycle after 8'hC0. Expect data_out=16'hC005 and credits=7.
3. Flush via in_last: send 8'hA5 with in_last=1. Expect data_out=16'h00A5, w pulse one cycle later, credits decremented.
4. Full stall: send 16 bytes, i.e. 8 words, with no rd_ack.
   - Expect credits=0 and in_ready=0 in IDLE; the 17th byte is held.
   - Pulse rd_ack once: credits=1, the 17th byte is accepted on the next edge.
5. Simultaneous events and overflow:
   - EMIT cycle coinciding with rd_ack: expect credits unchanged.
   - From reset, pulse rd_ack: expect credits stays 8 and overflow_err=1 until rst.
6. Reset mid-word: accept 8'h11, assert rst, release it, then send 8'h22 and 8'h33. Expect data_out=16'h3322; the 8'h11 is lost.
